// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS: controller states, opcode/funct
// values and the datapath select/ALU codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU operation map; funct_legal flags the supported subset.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_legal
);

  // Combinational funct lookup with an add/illegal fallback
  always_comb begin
    alucontrol  = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FUNCT_ADD: alucontrol = ALU_ADD;
      FUNCT_SUB: alucontrol = ALU_SUB;
      FUNCT_AND: alucontrol = ALU_AND;
      FUNCT_OR:  alucontrol = ALU_OR;
      FUNCT_SLT: alucontrol = ALU_SLT;
      default: begin
        alucontrol  = ALU_ADD;
        funct_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath, stalling
// on mem_ready and trapping unsupported op/funct encodings.
module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  localparam state_t ILLEGAL_NEXT = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] alu_funct_s;
  logic       funct_legal_s;
  logic       pcwrite_s;
  logic       branch_s;

  mips_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alucontrol  (alu_funct_s),
    .funct_legal (funct_legal_s)
  );

  assign state_o = state_r;

  // State register, reset straight to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; unused codes fall back to FETCH
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = funct_legal_s ? S_EXECUTE : ILLEGAL_NEXT;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEXEC;
          OP_J:         next_state_s = S_JUMP;
          default:      next_state_s = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   next_state_s = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state_s = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_ADDIEXEC: next_state_s = S_ADDIWB;
      S_ADDIWB:   next_state_s = S_FETCH;
      S_JUMP:     next_state_s = S_FETCH;
      S_HALT:     next_state_s = S_HALT;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    alucontrol = ALU_AND;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state_r)
        S_FETCH: begin
          alusrcb    = SRCB_FOUR;
          alucontrol = ALU_ADD;
          irwrite    = mem_ready;
          pcwrite_s  = mem_ready;
        end
        S_DECODE: begin
          alusrcb    = SRCB_IMMSH;
          alucontrol = ALU_ADD;
        end
        S_MEMADR, S_ADDIEXEC: begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          alucontrol = ALU_ADD;
        end
        S_MEMREAD: iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        // Strobe held until the memory accepts the write
        S_MEMWRITE: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca    = 1'b1;
          alucontrol = alu_funct_s;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = PCSRC_ALUOUT;
          branch_s   = 1'b1;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          pcsrc     = PCSRC_JUMP;
          pcwrite_s = 1'b1;
        end
        S_HALT:  illegal_op = 1'b1;
        default: illegal_op = 1'b0;
      endcase
    end else begin
      illegal_op = 1'b0;
    end
    pcen = pcwrite_s | (branch_s & zero);
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: the driver queues hand-computed per-cycle expectations,
// a negedge monitor pops them and compares against both controller variants.
module tb_mips_multicycle_controller;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  logic       pcen0, irwrite0, regwrite0, memwrite0, iord0, regdst0, memtoreg0, alusrca0, illegal_op0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic [3:0] state_o0;

  string q_lbl[$];
  outs_t q_exp[$];
  logic  q_c0[$];
  outs_t q_e0[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite), .iord(iord),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal_op(illegal_op), .state_o(state_o)
  );

  mips_multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen0), .irwrite(irwrite0), .regwrite(regwrite0), .memwrite(memwrite0), .iord(iord0),
    .regdst(regdst0), .memtoreg(memtoreg0), .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
    .alucontrol(alucontrol0), .illegal_op(illegal_op0), .state_o(state_o0)
  );

  function automatic outs_t mk(input logic [3:0] st, input logic pc, input logic ir, input logic rw,
                               input logic mw, input logic io, input logic rd, input logic m2r,
                               input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
                               input logic [2:0] alu, input logic ill);
    outs_t o;
    o.st = st; o.pcen = pc; o.irwrite = ir; o.regwrite = rw; o.memwrite = mw; o.iord = io;
    o.regdst = rd; o.memtoreg = m2r; o.alusrca = asa; o.alusrcb = asb; o.pcsrc = pcs;
    o.aluc = alu; o.ill = ill;
    return o;
  endfunction

  function automatic outs_t o_rst();     return mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0); endfunction
  function automatic outs_t o_fetch(input logic mr);
                                         return mk(4'd0,  mr,   mr,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0); endfunction
  function automatic outs_t o_decode();  return mk(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 3'b010, 1'b0); endfunction
  function automatic outs_t o_memadr();  return mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0); endfunction
  function automatic outs_t o_memrd();   return mk(4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0); endfunction
  function automatic outs_t o_memwb();   return mk(4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0); endfunction
  function automatic outs_t o_memwr();   return mk(4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0); endfunction
  function automatic outs_t o_exec(input logic [2:0] alu);
                                         return mk(4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, alu,    1'b0); endfunction
  function automatic outs_t o_aluwb();   return mk(4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0); endfunction
  function automatic outs_t o_branch(input logic z);
                                         return mk(4'd8,  z,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 3'b110, 1'b0); endfunction
  function automatic outs_t o_addiex();  return mk(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0); endfunction
  function automatic outs_t o_addiwb();  return mk(4'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0); endfunction
  function automatic outs_t o_jump();    return mk(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 3'b000, 1'b0); endfunction
  function automatic outs_t o_halt();    return mk(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1); endfunction

  task automatic drv(input string lbl, input logic rst_v, input logic [5:0] op_v, input logic [5:0] fn_v,
                     input logic z_v, input logic mr_v, input outs_t e, input logic c0, input outs_t e0);
    reset = rst_v; op = op_v; funct = fn_v; zero = z_v; mem_ready = mr_v;
    q_lbl.push_back(lbl); q_exp.push_back(e); q_c0.push_back(c0); q_e0.push_back(e0);
    @(posedge clk); #1;
  endtask

  task automatic d(input string lbl, input logic [5:0] op_v, input logic [5:0] fn_v,
                   input logic z_v, input logic mr_v, input outs_t e);
    drv(lbl, 1'b0, op_v, fn_v, z_v, mr_v, e, 1'b0, e);
  endtask

  // Monitor: one expectation per falling edge
  initial begin
    string lbl;
    outs_t e, e0, a, a0;
    logic  c0;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        lbl = q_lbl.pop_front(); e = q_exp.pop_front(); c0 = q_c0.pop_front(); e0 = q_e0.pop_front();
        a = mk(state_o, pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, illegal_op);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h (t=%0t)", lbl, a, e, $time);
        end
        if (c0) begin
          a0 = mk(state_o0, pcen0, irwrite0, regwrite0, memwrite0, iord0, regdst0, memtoreg0, alusrca0,
                  alusrcb0, pcsrc0, alucontrol0, illegal_op0);
          checks++;
          if (a0 !== e0) begin
            errors++;
            $display("FAIL %s_nohalt: got %h expected %h (t=%0t)", lbl, a0, e0, $time);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; op = OP_LW; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    q_lbl.push_back("reset_a"); q_exp.push_back(o_rst()); q_c0.push_back(1'b1); q_e0.push_back(o_rst());
    q_lbl.push_back("reset_b"); q_exp.push_back(o_rst()); q_c0.push_back(1'b1); q_e0.push_back(o_rst());
    mem_ready = 1'b0;
    #22 reset = 1'b0;
    @(posedge clk); #1;

    // lw, no stalls
    d("lw_fetch",   OP_LW, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("lw_decode",  OP_LW, 6'b000000, 1'b0, 1'b1, o_decode());
    d("lw_memadr",  OP_LW, 6'b000000, 1'b0, 1'b1, o_memadr());
    d("lw_memread", OP_LW, 6'b000000, 1'b0, 1'b1, o_memrd());
    d("lw_memwb",   OP_LW, 6'b000000, 1'b0, 1'b0, o_memwb());
    // sw with two stall cycles in MEMWRITE, preceded by a fetch stall
    d("sw_fetch_stall", OP_SW, 6'b000000, 1'b0, 1'b0, o_fetch(1'b0));
    d("sw_fetch",   OP_SW, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("sw_decode",  OP_SW, 6'b000000, 1'b0, 1'b0, o_decode());
    d("sw_memadr",  OP_SW, 6'b000000, 1'b0, 1'b0, o_memadr());
    d("sw_memwr1",  OP_SW, 6'b000000, 1'b0, 1'b0, o_memwr());
    d("sw_memwr2",  OP_SW, 6'b000000, 1'b0, 1'b0, o_memwr());
    d("sw_memwr3",  OP_SW, 6'b000000, 1'b0, 1'b1, o_memwr());
    // beq taken and not taken
    d("beq1_fetch", OP_BEQ, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("beq1_decode", OP_BEQ, 6'b000000, 1'b0, 1'b1, o_decode());
    d("beq_taken",  OP_BEQ, 6'b000000, 1'b1, 1'b1, o_branch(1'b1));
    d("beq2_fetch", OP_BEQ, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("beq2_decode", OP_BEQ, 6'b000000, 1'b0, 1'b1, o_decode());
    d("beq_nottaken", OP_BEQ, 6'b000000, 1'b0, 1'b1, o_branch(1'b0));
    // R-type slt
    d("slt_fetch",  OP_RTYPE, FUNCT_SLT, 1'b0, 1'b1, o_fetch(1'b1));
    d("slt_decode", OP_RTYPE, FUNCT_SLT, 1'b0, 1'b1, o_decode());
    d("slt_exec",   OP_RTYPE, FUNCT_SLT, 1'b0, 1'b1, o_exec(3'b111));
    d("slt_aluwb",  OP_RTYPE, FUNCT_SLT, 1'b0, 1'b1, o_aluwb());
    // R-type sub
    d("sub_fetch",  OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1, o_fetch(1'b1));
    d("sub_decode", OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1, o_decode());
    d("sub_exec",   OP_RTYPE, FUNCT_SUB, 1'b1, 1'b0, o_exec(3'b110));
    d("sub_aluwb",  OP_RTYPE, FUNCT_SUB, 1'b0, 1'b1, o_aluwb());
    // addi
    d("addi_fetch", OP_ADDI, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("addi_decode", OP_ADDI, 6'b000000, 1'b0, 1'b1, o_decode());
    d("addi_exec",  OP_ADDI, 6'b000000, 1'b0, 1'b1, o_addiex());
    d("addi_wb",    OP_ADDI, 6'b000000, 1'b0, 1'b1, o_addiwb());
    // j
    d("j_fetch",    OP_J, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("j_decode",   OP_J, 6'b000000, 1'b0, 1'b1, o_decode());
    d("j_jump",     OP_J, 6'b000000, 1'b0, 1'b0, o_jump());
    // illegal funct: halting variant traps, non-halting variant refetches
    drv("ill_fetch",  1'b0, OP_RTYPE, 6'b000111, 1'b0, 1'b1, o_fetch(1'b1), 1'b1, o_fetch(1'b1));
    drv("ill_decode", 1'b0, OP_RTYPE, 6'b000111, 1'b0, 1'b1, o_decode(),    1'b1, o_decode());
    drv("ill_halt0",  1'b0, OP_RTYPE, 6'b000111, 1'b0, 1'b1, o_halt(),      1'b1, o_fetch(1'b1));
    for (int i = 1; i < 20; i++) begin
      d($sformatf("ill_halt%0d", i), OP_RTYPE, 6'b000111, i[1], i[0], o_halt());
    end
    // reset leaves HALT, then reset in the middle of a stalled write
    drv("rst_halt", 1'b1, OP_SW, 6'b000000, 1'b0, 1'b1, o_rst(), 1'b1, o_rst());
    d("sw2_fetch",  OP_SW, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    d("sw2_decode", OP_SW, 6'b000000, 1'b0, 1'b1, o_decode());
    d("sw2_memadr", OP_SW, 6'b000000, 1'b0, 1'b1, o_memadr());
    d("sw2_memwr",  OP_SW, 6'b000000, 1'b0, 1'b0, o_memwr());
    drv("rst_memwr", 1'b1, OP_SW, 6'b000000, 1'b0, 1'b0, o_rst(), 1'b1, o_rst());
    d("post_rst_fetch", OP_SW, 6'b000000, 1'b0, 1'b1, o_fetch(1'b1));
    // unknown opcode also traps
    d("badop_decode", 6'b111111, 6'b000000, 1'b0, 1'b1, o_decode());
    d("badop_halt",   6'b111111, 6'b000000, 1'b0, 1'b1, o_halt());

    for (int i = 0; i < 5 && q_exp.size() != 0; i++) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
